// File: rtl/wb_src_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_src_arbiter_if
//  Purpose  : Bundle of request/grant/select signals between the write-back
//             source requesters, the arbiter and the write-back mux.
//  Signals  : req[3:0]   request lines, bit i = requester i
//             gnt[3:0]   one-hot grant (registered in the arbiter)
//             sel[1:0]   mux select, index of current or last owner
//             bus_valid  mux output currently owned
//             hold_exp   pulse: previous grant was force-ended by hold limit
//  Modports : master - arbiter side (drives gnt/sel/bus_valid/hold_exp)
//             slave  - requester / mux side (drives req)
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_src_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_valid;
    logic       hold_exp;

    modport master (
        input  req,
        output gnt,
        output sel,
        output bus_valid,
        output hold_exp
    );

    modport slave (
        output req,
        input  gnt,
        input  sel,
        input  bus_valid,
        input  hold_exp
    );
endinterface
`default_nettype wire

// File: rtl/wb_src_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_src_arbiter
//  Purpose  : Round-robin arbiter owning the 4:1 write-back mux select.
//             A grant is held while the owner keeps requesting, up to
//             MAX_HOLD cycles (0 = unlimited). Every handover inserts one
//             dead (IDLE) cycle.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - wb_src_arbiter_if.master (req in; gnt, sel,
//                    bus_valid, hold_exp out)
//  Params   : MAX_HOLD - max consecutive grant cycles per ownership (0 = none)
//             CNT_W    - hold counter width, 2**CNT_W must cover MAX_HOLD
//  Options  : ARB_PREEMPT_EN - requester 0 preempts any other owner; the
//             preempted owner's turn is preserved in the rotation.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_src_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wb_src_arbiter_if.master   bus
);

    localparam logic [CNT_W-1:0] c_MAX_HOLD = CNT_W'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [3:0]       r_gnt,      w_gnt_nxt;
    logic [1:0]       r_sel,      w_sel_nxt;
    logic [1:0]       r_ptr,      w_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic             r_hold_exp, w_hold_exp_nxt;

    logic [1:0]       w_scan_idx;
    logic [1:0]       w_win_idx;
    logic             w_win_any;
    logic             w_own_req;
    logic             w_hold_lim;

`ifdef ARB_PREEMPT_EN
    // Remembers who was preempted so requester 0's release resumes the
    // rotation right after them.
    logic             r_pre_pend,  w_pre_pend_nxt;
    logic [1:0]       r_pre_owner, w_pre_owner_nxt;
`endif

    // Owner index is r_sel while in GRANT.
    assign w_own_req  = bus.req[r_sel];
    assign w_hold_lim = (MAX_HOLD != 0) && (r_hold_cnt == c_MAX_HOLD);

    // Rotating priority scan starting at r_ptr. Iterating downwards lets the
    // closest-to-pointer requester overwrite the others.
    always_comb begin
        w_win_any  = 1'b0;
        w_win_idx  = r_ptr;
        w_scan_idx = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_scan_idx = r_ptr + 2'(i);
            if (bus.req[w_scan_idx]) begin
                w_win_any = 1'b1;
                w_win_idx = w_scan_idx;
            end
        end
`ifdef ARB_PREEMPT_EN
        if (r_pre_pend && bus.req[0]) begin
            w_win_any = 1'b1;
            w_win_idx = 2'd0;
        end
`endif
    end

    // Next-state / output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_hold_exp_nxt = 1'b0;
`ifdef ARB_PREEMPT_EN
        w_pre_pend_nxt  = r_pre_pend;
        w_pre_owner_nxt = r_pre_owner;
`endif
        case (r_state)
            ST_IDLE: begin
                // sel is left alone when nobody requests to avoid mux glitches
                if (w_win_any) begin
                    w_state_nxt    = ST_GRANT;
                    w_gnt_nxt      = 4'b0001 << w_win_idx;
                    w_sel_nxt      = w_win_idx;
                    w_hold_cnt_nxt = CNT_W'(1);
`ifdef ARB_PREEMPT_EN
                    if (w_win_idx != 2'd0) begin
                        w_pre_pend_nxt = 1'b0;
                    end
`endif
                end
            end
            ST_GRANT: begin
                if (!w_own_req || w_hold_lim) begin
                    w_state_nxt    = ST_IDLE;
                    w_gnt_nxt      = 4'b0000;
                    w_ptr_nxt      = r_sel + 2'd1;
                    w_hold_exp_nxt = w_own_req;
`ifdef ARB_PREEMPT_EN
                    if (r_sel == 2'd0 && r_pre_pend) begin
                        w_ptr_nxt      = r_pre_owner + 2'd1;
                        w_pre_pend_nxt = 1'b0;
                    end
`endif
                end else if (!(&r_hold_cnt)) begin
                    // saturate so an unlimited hold never wraps
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
`ifdef ARB_PREEMPT_EN
                // Preemption overrides everything: plain release, pointer
                // frozen, no hold-expiry pulse.
                if (r_sel != 2'd0 && bus.req[0]) begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = 4'b0000;
                    w_ptr_nxt       = r_ptr;
                    w_hold_exp_nxt  = 1'b0;
                    w_hold_cnt_nxt  = r_hold_cnt;
                    w_pre_pend_nxt  = 1'b1;
                    w_pre_owner_nxt = r_sel;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'b00;
            r_ptr      <= 2'b00;
            r_hold_cnt <= '0;
            r_hold_exp <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_hold_exp <= w_hold_exp_nxt;
        end
    end

`ifdef ARB_PREEMPT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_pend  <= 1'b0;
            r_pre_owner <= 2'b00;
        end else begin
            r_pre_pend  <= w_pre_pend_nxt;
            r_pre_owner <= w_pre_owner_nxt;
        end
    end
`endif

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.bus_valid = |r_gnt;
    assign bus.hold_exp  = r_hold_exp;

endmodule
`default_nettype wire

// File: tb/tb_wb_src_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_src_arbiter
//  Purpose  : Self-checking bench for wb_src_arbiter. Two instances
//             (MAX_HOLD=8 and MAX_HOLD=2) share the same request stimulus;
//             an integer-level ownership model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_src_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_src_arbiter_if if8 ();
    wb_src_arbiter_if if2 ();
    assign if8.req = req;
    assign if2.req = req;

    wb_src_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    wb_src_arbiter #(.MAX_HOLD(2), .CNT_W(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 means nobody holds the mux.
    int m_owner [2];
    int m_cnt   [2];
    int m_ptr   [2];
    int m_sel   [2];
    bit m_hexp  [2];
    int m_max   [2];
    initial begin
        m_max[0] = 8;
        m_max[1] = 2;
    end

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            int o, c, p, s;
            bit h;
            o = m_owner[k]; c = m_cnt[k]; p = m_ptr[k]; s = m_sel[k]; h = 1'b0;
            if (rst) begin
                o = -1; c = 0; p = 0; s = 0;
            end else if (o < 0) begin
                for (int i = 3; i >= 0; i--)
                    if (req[(p + i) % 4]) o = (p + i) % 4;
                if (o >= 0) begin
                    s = o;
                    c = 1;
                end
            end else if (!req[o]) begin
                p = (o + 1) % 4;
                o = -1;
            end else if (m_max[k] != 0 && c == m_max[k]) begin
                p = (o + 1) % 4;
                o = -1;
                h = 1'b1;
            end else begin
                c = c + 1;
            end
            m_owner[k] <= o;
            m_cnt[k]   <= c;
            m_ptr[k]   <= p;
            m_sel[k]   <= s;
            m_hexp[k]  <= h;
        end
    end

    function automatic logic [3:0] onehot(input int o);
        return (o < 0) ? 4'b0000 : (4'b0001 << o);
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("gnt8",  {28'd0, if8.gnt},       {28'd0, onehot(m_owner[0])});
        chk("sel8",  {30'd0, if8.sel},       32'(m_sel[0]));
        chk("bv8",   {31'd0, if8.bus_valid}, {31'd0, m_owner[0] >= 0});
        chk("hexp8", {31'd0, if8.hold_exp},  {31'd0, m_hexp[0]});
        chk("gnt2",  {28'd0, if2.gnt},       {28'd0, onehot(m_owner[1])});
        chk("sel2",  {30'd0, if2.sel},       32'(m_sel[1]));
        chk("bv2",   {31'd0, if2.bus_valid}, {31'd0, m_owner[1] >= 0});
        chk("hexp2", {31'd0, if2.hold_exp},  {31'd0, m_hexp[1]});
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("rst_gnt", {28'd0, if8.gnt}, 32'd0);
        chk("rst_sel", {30'd0, if8.sel}, 32'd0);
        chk("rst_bv",  {31'd0, if8.bus_valid}, 32'd0);
        chk("rst_hx",  {31'd0, if8.hold_exp}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seq [13];

        // Held request, hold limit 8: 8 grant cycles, expiry dead cycle, regrant
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold8_gnt", {28'd0, if8.gnt}, (i == 8) ? 32'h0 : 32'h4);
            chk("hold8_hexp", {31'd0, if8.hold_exp}, (i == 8) ? 32'd1 : 32'd0);
            chk("hold8_sel", {30'd0, if8.sel}, 32'd2);
        end

        // All requesting, hold limit 2: rotation with dead cycles
        do_reset();
        req = 4'b1111;
        seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("rr2_gnt", {28'd0, if2.gnt}, {28'd0, seq[i]});
            chk("rr2_bv",  {31'd0, if2.bus_valid}, {31'd0, |seq[i]});
        end

        // req[1] pulsed for 3 cycles
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pulse_gnt", {28'd0, if8.gnt}, (i < 3) ? 32'h2 : 32'h0);
            chk("pulse_sel", {30'd0, if8.sel}, 32'd1);
            chk("pulse_bv",  {31'd0, if8.bus_valid}, (i < 3) ? 32'd1 : 32'd0);
            if (i == 2) req = 4'b0000;
        end

        // Asynchronous reset in the middle of a grant to requester 3
        do_reset();
        req = 4'b1000;
        repeat (2) @(negedge clk);
        chk("ar_pre_gnt", {28'd0, if8.gnt}, 32'h8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_gnt", {28'd0, if8.gnt}, 32'h0);
        chk("ar_sel", {30'd0, if8.sel}, 32'd0);
        chk("ar_bv",  {31'd0, if8.bus_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_regnt", {28'd0, if8.gnt}, 32'h8);
        chk("ar_resel", {30'd0, if8.sel}, 32'd3);

        // Owner 2 drops while requester 3 raises in the same cycle
        do_reset();
        req = 4'b0100;
        repeat (3) @(negedge clk);
        chk("ho_own", {28'd0, if8.gnt}, 32'h4);
        req = 4'b1000;
        @(negedge clk);
        chk("ho_dead", {28'd0, if8.gnt}, 32'h0);
        chk("ho_dbv",  {31'd0, if8.bus_valid}, 32'd0);
        @(negedge clk);
        chk("ho_new", {28'd0, if8.gnt}, 32'h8);
        chk("ho_sel", {30'd0, if8.sel}, 32'd3);

        // Randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
